// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter and sequencer for a single-port 256x64 synchronous RAM.
// Serialises single-word read/write transactions and routes read data back to the issuer.
module ram_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_grant,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_grant,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          cen,
  output logic          wen,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_din,
  input  logic [DW-1:0] s_dout,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          cur_q, cur_d;
  logic          last_q, last_d;
  logic          win;
  logic          cen_d, wen_d, busy_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] din_d;
  logic          grant0_d, grant1_d, rvalid0_d, rvalid1_d;
  logic [DW-1:0] rdata0_d, rdata1_d;

  // m1 wins when alone, or on a tie when m0 was the previous winner
  assign win = m1_req & (~m0_req | ~last_q);

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    cen_d     = 1'b0;
    wen_d     = 1'b0;
    addr_d    = s_addr;
    din_d     = s_din;
    grant0_d  = 1'b0;
    grant1_d  = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = m0_rdata;
    rdata1_d  = m1_rdata;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d  = ACCESS;
          cur_d    = win;
          last_d   = win;
          cen_d    = 1'b1;
          wen_d    = win ? m1_wr : m0_wr;
          addr_d   = win ? m1_addr : m0_addr;
          if (win) din_d = m1_wr ? m1_wdata : '0;
          else     din_d = m0_wr ? m0_wdata : '0;
          grant0_d = ~win;
          grant1_d = win;
        end
      end
      ACCESS: begin
        // wen still holds the kind of the transaction being executed
        state_d = wen ? IDLE : RDATA;
      end
      RDATA: begin
        state_d = IDLE;
        if (cur_q) begin
          rvalid1_d = 1'b1;
          rdata1_d  = s_dout;
        end else begin
          rvalid0_d = 1'b1;
          rdata0_d  = s_dout;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cur_q     <= 1'b0;
      last_q    <= 1'b1;
      cen       <= 1'b0;
      wen       <= 1'b0;
      s_addr    <= '0;
      s_din     <= '0;
      m0_grant  <= 1'b0;
      m1_grant  <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      cen       <= cen_d;
      wen       <= wen_d;
      s_addr    <= addr_d;
      s_din     <= din_d;
      m0_grant  <= grant0_d;
      m1_grant  <= grant1_d;
      m0_rvalid <= rvalid0_d;
      m1_rvalid <= rvalid1_d;
      m0_rdata  <= rdata0_d;
      m1_rdata  <= rdata1_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 256x64 RAM attached.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0]  m0_addr, m1_addr;
  logic [63:0] m0_wdata, m1_wdata;
  logic        m0_grant, m0_rvalid, m1_grant, m1_rvalid;
  logic [63:0] m0_rdata, m1_rdata;
  logic        cen, wen, busy;
  logic [7:0]  s_addr;
  logic [63:0] s_din, s_dout;

  int n_cmp = 0;
  int n_bad = 0;
  int g0n = 0, g1n = 0, rv1n = 0, cen_n = 0, viol = 0;
  int gq[$];
  bit cen_prev = 1'b0;

  localparam logic [63:0] D10 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D20 = 64'hAAAA_0000_2020_5555;
  localparam logic [63:0] D30 = 64'h3030_BEEF_CAFE_0303;
  localparam logic [63:0] D40 = 64'h4040_4040_4040_4040;
  localparam logic [63:0] D41 = 64'h4141_0000_0000_4141;
  localparam logic [63:0] DFF = 64'hFFEE_DDCC_BBAA_9988;
  localparam logic [63:0] D50 = 64'h5050_1234_5678_5050;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_grant(m0_grant), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_grant(m1_grant), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .cen(cen), .wen(wen), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout),
    .busy(busy)
  );

  // Behavioural RAM: registered read, output forced to 0 when not enabled
  logic [63:0] mem [256];
  always @(posedge clk) begin
    if (cen) begin
      if (wen) mem[s_addr] <= s_din;
      s_dout <= wen ? 64'h0 : mem[s_addr];
    end else begin
      s_dout <= 64'h0;
    end
  end

  // Event monitor: grant order, pulse counts, protocol violations
  always @(negedge clk) begin
    if (m0_grant) begin gq.push_back(0); g0n++; end
    if (m1_grant) begin gq.push_back(1); g1n++; end
    if (m0_grant && m1_grant) viol++;
    if (m0_rvalid && m1_rvalid) viol++;
    if (cen && cen_prev) viol++;
    cen_prev = cen;
    if (m1_rvalid) rv1n++;
    if (cen) cen_n++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input bit m, input logic [7:0] a, input logic [63:0] d);
    int k = 0;
    if (m) begin m1_req = 1; m1_wr = 1; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = 1; m0_wr = 1; m0_addr = a; m0_wdata = d; end
    cyc(1);
    while (!(m ? m1_grant : m0_grant) && k < 10) begin cyc(1); k++; end
    check("prewrite_grant", 64'(m ? m1_grant : m0_grant), 64'd1);
    m0_req = 0; m1_req = 0;
    cyc(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cen"}, 64'(cen), 64'd0);
    check({tag, "_wen"}, 64'(wen), 64'd0);
    check({tag, "_saddr"}, 64'(s_addr), 64'd0);
    check({tag, "_sdin"}, s_din, 64'd0);
    check({tag, "_grants"}, 64'({m0_grant, m1_grant}), 64'd0);
    check({tag, "_rvalids"}, 64'({m0_rvalid, m1_rvalid}), 64'd0);
    check({tag, "_rdata0"}, m0_rdata, 64'd0);
    check({tag, "_rdata1"}, m1_rdata, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int ng, base_g1, base_rv1, base_cen;
    reset_n = 0;
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
    cyc(2);
    check_reset_vals("rst");
    reset_n = 1;

    // m0 write 0x10, then read it back
    m0_req = 1; m0_wr = 1; m0_addr = 8'h10; m0_wdata = D10;
    cyc(1);
    check("wr_cen", 64'(cen), 64'd1);
    check("wr_wen", 64'(wen), 64'd1);
    check("wr_saddr", 64'(s_addr), 64'h10);
    check("wr_sdin", s_din, D10);
    check("wr_grant", 64'({m0_grant, m1_grant}), 64'b10);
    check("wr_busy1", 64'(busy), 64'd1);
    m0_req = 0;
    cyc(1);
    check("wr_busy2", 64'(busy), 64'd0);
    check("wr_cen_off", 64'(cen), 64'd0);
    check("wr_saddr_hold", 64'(s_addr), 64'h10);
    m0_req = 1; m0_wr = 0;
    cyc(1);
    check("rd_grant", 64'(m0_grant), 64'd1);
    check("rd_cen_wen", 64'({cen, wen}), 64'b10);
    check("rd_sdin0", s_din, 64'd0);
    m0_req = 0;
    cyc(1);
    check("rd_busy_rdata", 64'(busy), 64'd1);
    check("rd_no_early_rvalid", 64'(m0_rvalid), 64'd0);
    cyc(1);
    check("rd_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'b10);
    check("rd_data", m0_rdata, D10);
    check("rd_busy_done", 64'(busy), 64'd0);
    cyc(1);
    check("rd_rvalid_pulse", 64'(m0_rvalid), 64'd0);
    check("rd_data_hold", m0_rdata, D10);

    // Preload, reset, then simultaneous reads
    do_write(1'b0, 8'h20, D20);
    do_write(1'b1, 8'h30, D30);
    reset_n = 0;
    cyc(1);
    check_reset_vals("rst2");
    reset_n = 1;
    m0_req = 1; m0_wr = 0; m0_addr = 8'h20;
    m1_req = 1; m1_wr = 0; m1_addr = 8'h30;
    cyc(1);
    check("tie_grant_first", 64'({m0_grant, m1_grant}), 64'b10);
    m0_req = 0;
    cyc(2);
    check("tie_m0_rvalid", 64'(m0_rvalid), 64'd1);
    check("tie_m0_data", m0_rdata, D20);
    check("tie_m1_wait", 64'(m1_grant), 64'd0);
    cyc(1);
    check("tie_m1_grant", 64'({m0_grant, m1_grant}), 64'b01);
    check("tie_m1_addr", 64'(s_addr), 64'h30);
    m1_req = 0;
    cyc(2);
    check("tie_m1_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'b01);
    check("tie_m1_data", m1_rdata, D30);
    check("tie_m0_data_hold", m0_rdata, D20);

    // Both hold req for six write transactions
    gq.delete();
    ng = 0;
    m0_req = 1; m0_wr = 1; m0_addr = 8'h40; m0_wdata = D40;
    m1_req = 1; m1_wr = 1; m1_addr = 8'h41; m1_wdata = D41;
    for (int i = 0; i < 40 && ng < 6; i++) begin
      cyc(1);
      ng += int'(m0_grant) + int'(m1_grant);
      if (ng >= 6) begin m0_req = 0; m1_req = 0; end
    end
    m0_req = 0; m1_req = 0;
    cyc(3);
    check("rr_count", 64'(gq.size()), 64'd6);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      check($sformatf("rr_order%0d", i), 64'(gq[i]), 64'(i % 2));

    // m1 write 0xFF then m0 read 0xFF back-to-back
    m1_req = 1; m1_wr = 1; m1_addr = 8'hFF; m1_wdata = DFF;
    cyc(1);
    check("raw_m1_grant", 64'(m1_grant), 64'd1);
    m1_req = 0;
    m0_req = 1; m0_wr = 0; m0_addr = 8'hFF;
    cyc(2);
    check("raw_m0_grant", 64'({m0_grant, m1_grant}), 64'b10);
    m0_req = 0;
    cyc(2);
    check("raw_m0_rvalid", 64'(m0_rvalid), 64'd1);
    check("raw_m0_data", m0_rdata, DFF);

    // Reset during RDATA of an m1 read
    base_rv1 = rv1n;
    m1_req = 1; m1_wr = 0; m1_addr = 8'h41;
    cyc(1);
    check("abort_grant", 64'(m1_grant), 64'd1);
    m1_req = 0;
    cyc(1);
    check("abort_in_rdata", 64'(busy), 64'd1);
    reset_n = 0;
    cyc(1);
    check_reset_vals("abort");
    reset_n = 1;
    cyc(2);
    check("abort_no_rvalid", 64'(rv1n - base_rv1), 64'd0);
    m0_req = 1; m0_wr = 0; m0_addr = 8'h20;
    m1_req = 1; m1_wr = 0; m1_addr = 8'h30;
    cyc(1);
    check("abort_tie_m0", 64'({m0_grant, m1_grant}), 64'b10);
    m0_req = 0;
    cyc(3);
    check("abort_tie_m1", 64'(m1_grant), 64'd1);
    m1_req = 0;
    cyc(3);

    // One-cycle m1 pulse while busy with an m0 write
    base_g1 = g1n;
    base_cen = cen_n;
    m0_req = 1; m0_wr = 1; m0_addr = 8'h50; m0_wdata = D50;
    cyc(1);
    check("pulse_m0_grant", 64'(m0_grant), 64'd1);
    m0_req = 0;
    m1_req = 1; m1_wr = 1; m1_addr = 8'h60; m1_wdata = 64'hDEAD;
    cyc(1);
    m1_req = 0;
    cyc(4);
    check("pulse_no_m1_grant", 64'(g1n - base_g1), 64'd0);
    check("pulse_one_access", 64'(cen_n - base_cen), 64'd1);
    check("pulse_last_addr", 64'(s_addr), 64'h50);

    check("protocol_violations", 64'(viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
